// File: rtl/ldpc_uart_pkg.sv
// Shared types and constants for the UART-to-LDPC front end.
package ldpc_uart_pkg;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, HOLD} state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  // Must match the receiver's bit-timing constants.
  localparam int unsigned CLK_FREQ        = 100_000_000;
  localparam int unsigned UART_BPS        = 115_200;
  localparam int unsigned BIT_CYC         = CLK_FREQ / UART_BPS;
  localparam int unsigned TIMEOUT_CYC_DEF = 20 * BIT_CYC;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_assembler_if.sv
// Byte-stream input and message handshake/status bundle of the frame assembler.
interface uart_frame_assembler_if #(
  parameter int unsigned MSG_BYTES = 8
);
  localparam int unsigned MSG_W = MSG_BYTES * 8;

  logic             rx_done;
  logic [7:0]       rx_data;
  logic [MSG_W-1:0] msg_data;
  logic             msg_valid;
  logic             msg_ready;
  logic             busy;
  logic             chk_err;
  logic             tmo_err;
  logic             ovr_err;

  modport master (
    output rx_done, rx_data, msg_ready,
    input  msg_data, msg_valid, busy, chk_err, tmo_err, ovr_err
  );

  modport slave (
    input  rx_done, rx_data, msg_ready,
    output msg_data, msg_valid, busy, chk_err, tmo_err, ovr_err
  );
endinterface

// File: rtl/frame_timeout_timer.sv
// Inter-byte cycle counter; expire_c fires on the last idle cycle of the window.
module frame_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire_c
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;

  // A coincident clr (byte arrival) always beats expiry.
  assign expire_c = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (clr || !en || expire_c) cnt_q <= '0;
    else                            cnt_q <= cnt_q + CNT_W'(1);
  end
endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles SYNC + payload + XOR-checksum frames into one message word with valid/ready.
module uart_frame_assembler
  import ldpc_uart_pkg::*;
#(
  parameter int unsigned MSG_BYTES   = 8,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  uart_frame_assembler_if.slave bus
);
  localparam int unsigned MSG_W = MSG_BYTES * 8;
  localparam int unsigned IDX_W = idx_width(MSG_BYTES);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [MSG_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             chk_q, chk_d;
  logic             tmo_q, tmo_d;
  logic             ovr_q, ovr_d;
  logic             expire_c;

  frame_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       ((state_q == PAYLOAD) || (state_q == CHECK)),
    .clr      (bus.rx_done),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      chk_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      chk_q   <= chk_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    chk_d   = 1'b0;
    tmo_d   = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_done && (bus.rx_data == SYNC_BYTE)) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      PAYLOAD: begin
        if (bus.rx_done) begin
          for (int unsigned k = 0; k < MSG_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) data_d[8*k +: 8] = bus.rx_data;
          end
          acc_d = acc_q ^ bus.rx_data;
          if (idx_q == IDX_W'(MSG_BYTES - 1)) state_d = CHECK;
          else                                idx_d   = idx_q + IDX_W'(1);
        end else if (expire_c) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      CHECK: begin
        if (bus.rx_done) begin
          if (bus.rx_data == acc_q) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            chk_d   = 1'b1;
          end
        end else if (expire_c) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      HOLD: begin
        // A byte here is dropped even on the accept cycle; it never counts as SYNC.
        if (bus.rx_done)   ovr_d   = 1'b1;
        if (bus.msg_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == HOLD);
    busy_d  = (state_d == PAYLOAD) || (state_d == CHECK);
  end

  assign bus.msg_data  = data_q;
  assign bus.msg_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.chk_err   = chk_q;
  assign bus.tmo_err   = tmo_q;
  assign bus.ovr_err   = ovr_q;
endmodule
